// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared word type, width and corrector state encoding for the TRNG front end
package trng_pkg;
   localparam int TRNG_WORD_W = 32;

   typedef logic [TRNG_WORD_W-1:0] trng_word_t;

   typedef enum logic {
      WAIT_A = 1'b0,
      WAIT_B = 1'b1
   } trng_vn_state_e;
endpackage

// File: rtl/trng_word_fifo.sv
// rtl/trng_word_fifo.sv - registered word FIFO; flush empties it, push and pop may share a cycle
module trng_word_fifo
   import trng_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  trng_word_t               push_data,
   input  logic                     pop,
   output trng_word_t               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   trng_word_t      mem_q [DEPTH];
   trng_word_t      mem_d [DEPTH];
   logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]     level_q, level_d;
   logic            push_ok, pop_ok;

   assign full  = (level_q == FULL_LVL);
   assign empty = (level_q == '0);
   assign level = level_q;
   assign head  = mem_q[rd_q];

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      level_d = level_q;
      push_ok = push && !full && !flush;
      pop_ok  = pop && !empty && !flush;
      if (flush) begin
         wr_d    = '0;
         rd_d    = '0;
         level_d = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_d = rd_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
      end
   end
endmodule

// File: rtl/trng_entropy_conditioner.sv
// rtl/trng_entropy_conditioner.sv - sampled von Neumann corrector packing bits into a word FIFO
// Repetition-count health test is built only when TRNG_HEALTH_TEST_EN is defined.
module trng_entropy_conditioner
   import trng_pkg::*;
#(
   parameter int SAMPLE_DIV = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int REP_LIMIT  = 32
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          raw_bit,
   output logic [TRNG_WORD_W-1:0]        word_data,
   output logic                          word_valid,
   input  logic                          word_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          health_fail
);
   logic            raw_meta_q, raw_meta_d, raw_s_q, raw_s_d;
   logic [7:0]      div_q, div_d;
   trng_vn_state_e  state_q, state_d;
   logic            a_q, a_d;
   trng_word_t      acc_q, acc_d, word_next, push_data;
   logic [5:0]      cnt_q, cnt_d;
   logic            pend_q, pend_d;
   logic            strobe, emit, push, fifo_full, fifo_empty;
   logic            health_trip, health_stop;

   always_comb begin
      raw_meta_d = raw_bit;
      raw_s_d    = raw_meta_q;
      strobe     = enable && !health_stop && (div_q == 8'(SAMPLE_DIV - 1));
      div_d      = (!enable || health_stop || strobe) ? 8'd0 : div_q + 8'd1;
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      emit    = 1'b0;
      if (!enable) begin
         state_d = WAIT_A;
         a_d     = 1'b0;
      end else if (strobe) begin
         case (state_q)
            WAIT_A: begin
               a_d     = raw_s_q;
               state_d = WAIT_B;
            end
            default: begin
               emit    = a_q ^ raw_s_q;
               state_d = WAIT_A;
            end
         endcase
      end
   end

   // A completed word that finds the FIFO full parks in acc_q; bits emitted meanwhile are dropped.
   always_comb begin
      word_next = {acc_q[TRNG_WORD_W-2:0], a_q};
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      push      = 1'b0;
      push_data = word_next;
      if (!enable || health_trip) begin
         acc_d  = '0;
         cnt_d  = '0;
         pend_d = 1'b0;
      end else if (pend_q) begin
         if (!fifo_full) begin
            push      = 1'b1;
            push_data = acc_q;
            pend_d    = 1'b0;
            acc_d     = '0;
         end
      end else if (emit) begin
         if (cnt_q == 6'(TRNG_WORD_W - 1)) begin
            cnt_d = '0;
            if (fifo_full) begin
               pend_d = 1'b1;
               acc_d  = word_next;
            end else begin
               push  = 1'b1;
               acc_d = '0;
            end
         end else begin
            acc_d = word_next;
            cnt_d = cnt_q + 6'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         raw_meta_q <= 1'b0;
         raw_s_q    <= 1'b0;
         div_q      <= '0;
         state_q    <= WAIT_A;
         a_q        <= 1'b0;
         acc_q      <= '0;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
      end else begin
         raw_meta_q <= raw_meta_d;
         raw_s_q    <= raw_s_d;
         div_q      <= div_d;
         state_q    <= state_d;
         a_q        <= a_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
      end
   end

`ifdef TRNG_HEALTH_TEST_EN
   logic [7:0] rep_q, rep_d;
   logic       prev_q, prev_d, seen_q, seen_d, fail_q, fail_d;

   always_comb begin
      rep_d       = rep_q;
      prev_d      = prev_q;
      seen_d      = seen_q;
      fail_d      = fail_q;
      health_trip = 1'b0;
      if (!enable) begin
         rep_d  = '0;
         prev_d = 1'b0;
         seen_d = 1'b0;
         fail_d = 1'b0;
      end else if (strobe) begin
         prev_d = raw_s_q;
         seen_d = 1'b1;
         rep_d  = (seen_q && (raw_s_q == prev_q)) ? rep_q + 8'd1 : 8'd1;
         if (rep_d == 8'(REP_LIMIT)) begin
            health_trip = 1'b1;
            fail_d      = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rep_q  <= '0;
         prev_q <= 1'b0;
         seen_q <= 1'b0;
         fail_q <= 1'b0;
      end else begin
         rep_q  <= rep_d;
         prev_q <= prev_d;
         seen_q <= seen_d;
         fail_q <= fail_d;
      end
   end

   assign health_stop = fail_q;
   assign health_fail = fail_q;
`else
   logic unused_rep_limit;
   assign unused_rep_limit = ^REP_LIMIT;
   assign health_trip      = 1'b0;
   assign health_stop      = 1'b0;
   assign health_fail      = 1'b0;
`endif

   trng_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (health_trip),
      .push      (push),
      .push_data (push_data),
      .pop       (word_ready),
      .head      (word_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign word_valid = !fifo_empty;
endmodule

// File: tb/tb_trng_entropy_conditioner.sv
// tb/tb_trng_entropy_conditioner.sv - directed bench with a pair-decoding word model and scoreboard
// Health-test expectations follow TRNG_HEALTH_TEST_EN.
module tb_trng_entropy_conditioner;
   localparam int SAMPLE_DIV = 1;
   localparam int FIFO_DEPTH = 4;
   localparam int REP_LIMIT  = 32;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        raw_bit = 1'b0;
   logic        word_ready = 1'b0;
   logic [31:0] word_data;
   logic        word_valid;
   logic [2:0]  fifo_level;
   logic        health_fail;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   bit          sq[$];

   always #5 clock = ~clock;

   trng_entropy_conditioner #(
      .SAMPLE_DIV (SAMPLE_DIV),
      .FIFO_DEPTH (FIFO_DEPTH),
      .REP_LIMIT  (REP_LIMIT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .raw_bit     (raw_bit),
      .word_data   (word_data),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .fifo_level  (fifo_level),
      .health_fail (health_fail)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic void add_pair(input bit a, input bit b);
      sq.push_back(a);
      sq.push_back(b);
   endfunction

   function automatic void add_word(input logic [31:0] w);
      for (int j = 31; j >= 0; j--) add_pair(w[j], !w[j]);
   endfunction

   // Model: decode sample pairs (10 -> 1, 01 -> 0, else nothing), first bit lands in bit 31.
   function automatic void model_stream();
      bit bits[$];
      for (int i = 0; i + 1 < sq.size(); i += 2) begin
         if (sq[i] != sq[i+1]) bits.push_back(sq[i]);
      end
      for (int w = 0; (w + 1) * 32 <= bits.size(); w++) begin
         logic [31:0] wd;
         for (int k = 0; k < 32; k++) wd[31-k] = bits[w*32 + k];
         exp_q.push_back(wd);
      end
   endfunction

   // Sample i is taken two cycles after it is driven, so enable rises with the third bit.
   task automatic run_stream();
      model_stream();
      for (int i = 0; i < sq.size(); i++) begin
         raw_bit = sq[i];
         if (i == 2) enable = 1'b1;
         tick();
      end
      sq.delete();
   endtask

   task automatic finish_stream();
      tick();
      tick();
   endtask

   task automatic stop_enable();
      enable = 1'b0;
      tick();
   endtask

   task automatic drain();
      int n = 0;
      word_ready = 1'b1;
      while (word_valid && n < 64) begin
         tick();
         n++;
      end
      word_ready = 1'b0;
      chk("drain_done", 32'(word_valid), 32'd0);
      chk("words_outstanding", 32'(exp_q.size()), 32'd0);
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         chk("level_range", 32'(fifo_level <= 3'(FIFO_DEPTH)), 32'd1);
         chk("valid_vs_level", 32'(word_valid), 32'(fifo_level != 3'd0));
         if (word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL pop_unexpected: actual=%0h required=no word", word_data);
            end else begin
               chk("pop_data", word_data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      repeat (3) tick();
      @(negedge clock);
      chk("reset_word_data", word_data, 32'd0);
      chk("reset_word_valid", 32'(word_valid), 32'd0);
      chk("reset_fifo_level", 32'(fifo_level), 32'd0);
      chk("reset_health_fail", 32'(health_fail), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      for (int p = 0; p < 32; p++) add_pair(1'b1, 1'b0);
      run_stream();
      tick();
      @(negedge clock);
      chk("ones_valid_before", 32'(word_valid), 32'd0);
      tick();
      @(negedge clock);
      chk("ones_valid_after", 32'(word_valid), 32'd1);
      chk("ones_data", word_data, 32'hFFFF_FFFF);
      stop_enable();
      drain();

      add_word(32'hAAAA_AAAA);
      run_stream();
      finish_stream();
      chk("alt_data", word_data, 32'hAAAA_AAAA);
      chk("alt_level", 32'(fifo_level), 32'd1);
      stop_enable();
      drain();

      for (int p = 0; p < 32; p++) add_pair(1'b0, 1'b1);
      run_stream();
      finish_stream();
      chk("zeros_data", word_data, 32'h0000_0000);
      chk("zeros_valid", 32'(word_valid), 32'd1);
      stop_enable();
      drain();

      for (int p = 0; p < 32; p++) begin
         add_pair(1'b1, 1'b0);
         add_pair(bit'(p % 2), bit'(p % 2));
      end
      run_stream();
      finish_stream();
      chk("skip_data", word_data, 32'hFFFF_FFFF);
      chk("skip_level", 32'(fifo_level), 32'd1);
      stop_enable();
      drain();

      add_word(32'h1234_5678);
      add_word(32'h9ABC_DEF0);
      add_word(32'h0F0F_0F0F);
      add_word(32'hDEAD_BEEF);
      add_word(32'hCAFE_F00D);
      run_stream();
      finish_stream();
      word_ready = 1'b1;
      @(negedge clock);
      chk("ovf_level_sat", 32'(fifo_level), 32'd4);
      chk("ovf_head", word_data, 32'h1234_5678);
      tick();
      word_ready = 1'b0;
      @(negedge clock);
      chk("ovf_level_after_pop", 32'(fifo_level), 32'd3);
      tick();
      @(negedge clock);
      chk("ovf_pending_pushed", 32'(fifo_level), 32'd4);
      stop_enable();
      drain();

      for (int p = 0; p < 20; p++) add_pair(1'b0, 1'b1);
      run_stream();
      finish_stream();
      chk("partial_no_word", 32'(word_valid), 32'd0);
      stop_enable();
      for (int p = 0; p < 32; p++) add_pair(1'b1, 1'b0);
      run_stream();
      finish_stream();
      chk("reenable_data", word_data, 32'hFFFF_FFFF);
      chk("reenable_level", 32'(fifo_level), 32'd1);
      stop_enable();
      drain();

      add_word(32'h600D_F00D);
      run_stream();
      finish_stream();
      stop_enable();
      for (int i = 0; i < 32; i++) sq.push_back(1'b1);
      run_stream();
      tick();
      @(negedge clock);
      chk("health_before_limit", 32'(health_fail), 32'd0);
      tick();
      @(negedge clock);
`ifdef TRNG_HEALTH_TEST_EN
      chk("health_set", 32'(health_fail), 32'd1);
      chk("health_level_flushed", 32'(fifo_level), 32'd0);
      chk("health_valid_dropped", 32'(word_valid), 32'd0);
      exp_q.delete();
      enable = 1'b0;
      tick();
      @(negedge clock);
      chk("health_cleared", 32'(health_fail), 32'd0);
`else
      chk("health_tied_low", 32'(health_fail), 32'd0);
      chk("health_fifo_kept", 32'(fifo_level), 32'd1);
      stop_enable();
`endif
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
